ignition_gear_ctrl: RTL and testbench
=====================================

# ignition_gear_ctrl

Parametrised ignition and gear-selector controller for the car simulator, replacing the inline power-state FSM and gear register in the top level. It debounces the keypad inputs and runs a four-state ignition FSM with a timed crank phase. It enforces speed and brake interlocks on every gear change. Its outputs drive the vehicle logic, displays, steering and sound units.

## Interface
Parameters:
- SPD_W, 8, width of the speed input
- DEBOUNCE_N, 3, number of consecutive identical tick_spd samples needed to accept a key level (1..15)
- CRANK_SEC, 2, number of tick_1s pulses the start key must be held in CRANK (1..15)

Ports:
- CLK  in  1  system clock
- global_safe_rst  in  1  asynchronous, active-high reset
- tick_spd  in  1  one-cycle key-sampling strobe
- tick_1s  in  1  one-cycle 1 Hz strobe
- key_start  in  1  ignition key (raw)
- key_brake  in  1  foot brake (raw)
- key_p, key_r, key_n, key_d  in  1 each  gear keys (raw)
- speed  in  SPD_W  current vehicle speed
- power_state  out  2  OFF=0, ACC=1, RUN=2, CRANK=3
- engine_on  out  1  power_state==RUN
- acc_on  out  1  power_state!=OFF
- gear  out  4  P=3, R=6, N=9, D=12
- shift_reject  out  1  one-cycle pulse when a gear request is refused
- start_fail  out  1  one-cycle pulse when a crank is aborted

## Operation
- Debounce: each of the 6 keys has a counter that runs only on tick_spd. The debounced level changes after DEBOUNCE_N consecutive samples that differ from it. A press event is a rising edge of a debounced level.
- Gear requests are evaluated on press events with priority P > R > N > D. Only one request is handled per cycle.
- Gear interlocks:
  - Entering P or R requires speed==0.
  - Leaving P requires brake held (debounced) and acc_on.
  - R→D and D→R require speed==0.
  - N is always accepted.
  - A refused request leaves gear unchanged and pulses shift_reject.
  - A request for the current gear is a no-op with no pulse.
- Ignition FSM, advanced on a key_start press event:
  - OFF: if brake is held and gear is P or N → CRANK; otherwise → ACC.
  - ACC: if brake is held and gear is P or N → CRANK; otherwise → OFF.
  - CRANK:
    - Crank counter clears on entry and increments on each tick_1s while key_start (debounced) is high.
    - When the counter reaches CRANK_SEC → RUN.
    - If the debounced key_start falls first → ACC and start_fail pulses.
  - RUN: a press event with speed==0 → OFF. With speed!=0 the event is ignored.
- All outputs are registered.

## Timing
- Reset values: power_state=OFF, engine_on=0, acc_on=0, gear=P, shift_reject=0, start_fail=0. Debounce levels and counters reset to 0.
- Key latency: a raw level change is accepted DEBOUNCE_N tick_spd strobes later. The state or gear update follows 1 CLK after that.
- The crank phase takes exactly CRANK_SEC tick_1s pulses after CRANK entry. A tick_1s in the entry cycle is not counted.
- Same-cycle tick_1s and key_start release in CRANK: release wins, giving ACC and start_fail.
- Same-cycle gear press event and ignition transition: both take effect. Interlocks use pre-transition acc_on.
- Reset asserted mid-crank or mid-debounce aborts immediately. No start_fail pulse is produced.
- speed is sampled combinationally in the evaluating cycle. No synchronisation is done here.

## Configuration
- AUTO_PARK_EN defined: on RUN→OFF, or ACC→OFF, with speed==0, gear is forced to P in the same cycle. No shift_reject is produced.
- AUTO_PARK_EN undefined: gear is retained across power-state changes.

## Structure
- Shared package car_sim_pkg holds:
  - gear codes GEAR_P/R/N/D (4-bit)
  - power-state encodings PWR_OFF/ACC/RUN/CRANK
- Sub-module key_debouncer (parameter DEBOUNCE_N; ports CLK, global_safe_rst, tick, raw, level, rise) is instantiated 6 times.
- Ignition FSM and gear logic stay in ignition_gear_ctrl.

## Test plan
- DEBOUNCE_N=3: key_d pulse high for 2 tick_spd then low → gear stays P. Held 3 ticks with brake held and ACC → gear=D.
- OFF, brake held, gear P, key_start press held 2 tick_1s → CRANK, then RUN. engine_on=1 exactly 1 CLK after the 2nd tick_1s.
- CRANK, key_start released after 1 tick_1s → power_state=ACC and a single-cycle start_fail.
- RUN, gear D, speed=40, press key_r → gear stays D, shift_reject=1 for 1 cycle. Press key_start → stays RUN.
- key_p and key_n pressed the same sample at speed=0 → gear=P. Speed=0, RUN, press key_start → OFF; gear=P with AUTO_PARK_EN, unchanged (N) without it.
- Assert global_safe_rst during CRANK → all outputs at reset values next cycle; no start_fail.

Source files
------------

// File: rtl/car_sim_pkg.sv
// Shared car simulator definitions: gear codes, power-state encodings and
// the bit positions of the keypad inputs in the debounced key vectors.
package car_sim_pkg;

    localparam logic [3:0] GEAR_P = 4'd3;
    localparam logic [3:0] GEAR_R = 4'd6;
    localparam logic [3:0] GEAR_N = 4'd9;
    localparam logic [3:0] GEAR_D = 4'd12;

    typedef enum logic [1:0] {
        PWR_OFF   = 2'd0,
        PWR_ACC   = 2'd1,
        PWR_RUN   = 2'd2,
        PWR_CRANK = 2'd3
    } pwr_state_t;

    localparam int KEY_START = 0;
    localparam int KEY_BRAKE = 1;
    localparam int KEY_P     = 2;
    localparam int KEY_R     = 3;
    localparam int KEY_N     = 4;
    localparam int KEY_D     = 5;
    localparam int KEY_NUM   = 6;

    // Cranking is only allowed with the box in a non-driving position.
    function automatic logic gear_is_safe_start(input logic [3:0] g);
        return (g == GEAR_P) || (g == GEAR_N);
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Single-key debouncer: the accepted level follows the raw input only after
// DEBOUNCE_N consecutive tick samples that disagree with the current level.
// rise is a registered one-cycle pulse on an accepted 0->1 change.
module key_debouncer #(
    parameter int DEBOUNCE_N = 3
) (
    input  logic CLK,
    input  logic global_safe_rst,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic [3:0] cnt_reg;

    // Count disagreeing samples; any agreeing sample restarts the run.
    always_ff @(posedge CLK or posedge global_safe_rst) begin
        if (global_safe_rst) begin
            cnt_reg <= 4'd0;
            level   <= 1'b0;
            rise    <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (tick) begin
                if (raw == level) begin
                    cnt_reg <= 4'd0;
                end else if (cnt_reg == 4'(DEBOUNCE_N - 1)) begin
                    cnt_reg <= 4'd0;
                    level   <= raw;
                    rise    <= raw;
                end else begin
                    cnt_reg <= cnt_reg + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/ignition_gear_ctrl.sv
// Ignition and gear-selector controller: debounces the keypad, runs the
// OFF/ACC/CRANK/RUN power FSM with a timed crank, and applies speed/brake
// interlocks to gear requests.
// Optional feature: define AUTO_PARK_EN to force gear P when the car is
// switched off from RUN or ACC while stationary.
module ignition_gear_ctrl
    import car_sim_pkg::*;
#(
    parameter int SPD_W      = 8,
    parameter int DEBOUNCE_N = 3,
    parameter int CRANK_SEC  = 2
) (
    input  logic             CLK,
    input  logic             global_safe_rst,
    input  logic             tick_spd,
    input  logic             tick_1s,
    input  logic             key_start,
    input  logic             key_brake,
    input  logic             key_p,
    input  logic             key_r,
    input  logic             key_n,
    input  logic             key_d,
    input  logic [SPD_W-1:0] speed,
    output logic [1:0]       power_state,
    output logic             engine_on,
    output logic             acc_on,
    output logic [3:0]       gear,
    output logic             shift_reject,
    output logic             start_fail
);

    logic [KEY_NUM-1:0] key_raw;
    logic [KEY_NUM-1:0] key_lvl;
    logic [KEY_NUM-1:0] key_rise;

    assign key_raw = {key_d, key_n, key_r, key_p, key_brake, key_start};

    genvar gi;
    generate
        for (gi = 0; gi < KEY_NUM; gi++) begin : g_deb
            key_debouncer #(
                .DEBOUNCE_N (DEBOUNCE_N)
            ) u_deb (
                .CLK             (CLK),
                .global_safe_rst (global_safe_rst),
                .tick            (tick_spd),
                .raw             (key_raw[gi]),
                .level           (key_lvl[gi]),
                .rise            (key_rise[gi])
            );
        end
    endgenerate

    // Gear keys only act on presses and the brake only as a level.
    logic unused_keys;
    assign unused_keys = &{1'b0, key_lvl[KEY_D:KEY_P], key_rise[KEY_BRAKE]};

    pwr_state_t pwr_reg;
    logic [3:0] crank_reg;
    logic [3:0] gear_reg;
    logic       speed_zero;
    logic       crank_ok;
    logic       ign_to_off;
    logic       auto_park;

    assign speed_zero  = (speed == '0);
    assign crank_ok    = key_lvl[KEY_BRAKE] && gear_is_safe_start(gear_reg);
    assign ign_to_off  = key_rise[KEY_START] &&
                         (((pwr_reg == PWR_RUN) && speed_zero) ||
                          ((pwr_reg == PWR_ACC) && !crank_ok));
    assign power_state = pwr_reg;
    assign gear        = gear_reg;

`ifdef AUTO_PARK_EN
    assign auto_park = ign_to_off && speed_zero;
`else
    assign auto_park = 1'b0;
`endif

    // Power FSM with crank timer; engine_on/acc_on follow the next state.
    always_ff @(posedge CLK or posedge global_safe_rst) begin
        if (global_safe_rst) begin
            pwr_reg    <= PWR_OFF;
            crank_reg  <= 4'd0;
            engine_on  <= 1'b0;
            acc_on     <= 1'b0;
            start_fail <= 1'b0;
        end else begin
            start_fail <= 1'b0;
            case (pwr_reg)
                PWR_OFF, PWR_ACC: begin
                    if (key_rise[KEY_START]) begin
                        if (crank_ok) begin
                            pwr_reg   <= PWR_CRANK;
                            crank_reg <= 4'd0;
                            acc_on    <= 1'b1;
                        end else if (pwr_reg == PWR_OFF) begin
                            pwr_reg <= PWR_ACC;
                            acc_on  <= 1'b1;
                        end else begin
                            pwr_reg <= PWR_OFF;
                            acc_on  <= 1'b0;
                        end
                    end
                end
                PWR_CRANK: begin
                    // Releasing the key beats a coincident 1 s tick.
                    if (!key_lvl[KEY_START]) begin
                        pwr_reg    <= PWR_ACC;
                        start_fail <= 1'b1;
                    end else if (tick_1s) begin
                        if (crank_reg == 4'(CRANK_SEC - 1)) begin
                            pwr_reg   <= PWR_RUN;
                            engine_on <= 1'b1;
                        end else begin
                            crank_reg <= crank_reg + 4'd1;
                        end
                    end
                end
                default: begin
                    if (ign_to_off) begin
                        pwr_reg   <= PWR_OFF;
                        engine_on <= 1'b0;
                        acc_on    <= 1'b0;
                    end
                end
            endcase
        end
    end

    logic       req_valid;
    logic [3:0] req_gear;
    logic       needs_stop;
    logic       park_release_ok;
    logic       shift_ok;

    // Pick the highest-priority press and decide whether it may be honoured.
    always_comb begin
        req_valid = 1'b1;
        req_gear  = GEAR_P;
        if (key_rise[KEY_P]) begin
            req_gear = GEAR_P;
        end else if (key_rise[KEY_R]) begin
            req_gear = GEAR_R;
        end else if (key_rise[KEY_N]) begin
            req_gear = GEAR_N;
        end else if (key_rise[KEY_D]) begin
            req_gear = GEAR_D;
        end else begin
            req_valid = 1'b0;
        end
        needs_stop = (req_gear == GEAR_P) || (req_gear == GEAR_R) ||
                     ((gear_reg == GEAR_R) && (req_gear == GEAR_D)) ||
                     ((gear_reg == GEAR_D) && (req_gear == GEAR_R));
        park_release_ok = (gear_reg != GEAR_P) || (key_lvl[KEY_BRAKE] && acc_on);
        shift_ok = (req_gear == GEAR_N) ||
                   ((!needs_stop || speed_zero) && park_release_ok);
    end

    // Gear register; an auto-park overrides any same-cycle request silently.
    always_ff @(posedge CLK or posedge global_safe_rst) begin
        if (global_safe_rst) begin
            gear_reg     <= GEAR_P;
            shift_reject <= 1'b0;
        end else begin
            shift_reject <= 1'b0;
            if (auto_park) begin
                gear_reg <= GEAR_P;
            end else if (req_valid && (req_gear != gear_reg)) begin
                if (shift_ok) begin
                    gear_reg <= req_gear;
                end else begin
                    shift_reject <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ignition_gear_ctrl.sv
// Self-checking bench for ignition_gear_ctrl: a table of key/tick steps with
// hand-derived results, hand-written crank/abort/reset sequences, and a
// randomized phase, all cross-checked every cycle against a behavioural model.
module tb_ignition_gear_ctrl;
    import car_sim_pkg::*;

    localparam int DN = 3;
    localparam int CS = 2;
`ifdef AUTO_PARK_EN
    localparam bit AUTO_PARK = 1'b1;
`else
    localparam bit AUTO_PARK = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       global_safe_rst = 1'b1;
    logic       tick_spd = 1'b0, tick_1s = 1'b0;
    logic       key_start = 1'b0, key_brake = 1'b0;
    logic       key_p = 1'b0, key_r = 1'b0, key_n = 1'b0, key_d = 1'b0;
    logic [7:0] speed = 8'd0;
    logic [1:0] power_state;
    logic       engine_on, acc_on, shift_reject, start_fail;
    logic [3:0] gear;

    ignition_gear_ctrl #(.SPD_W(8), .DEBOUNCE_N(DN), .CRANK_SEC(CS)) dut (
        .CLK(CLK), .global_safe_rst(global_safe_rst), .tick_spd(tick_spd),
        .tick_1s(tick_1s), .key_start(key_start), .key_brake(key_brake),
        .key_p(key_p), .key_r(key_r), .key_n(key_n), .key_d(key_d),
        .speed(speed), .power_state(power_state), .engine_on(engine_on),
        .acc_on(acc_on), .gear(gear), .shift_reject(shift_reject),
        .start_fail(start_fail)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_hist [KEY_NUM];
    bit          m_lvl  [KEY_NUM];
    bit          m_rise [KEY_NUM];
    logic [1:0]  m_pwr;
    logic [3:0]  m_gear;
    int          m_crank_ticks;
    bit          m_rej, m_fail;

    function automatic bit gear_ok(input logic [3:0] cur, input logic [3:0] tgt,
                                   input bit spd0, input bit brake, input bit acc);
        if (tgt == GEAR_N) return 1'b1;
        if ((tgt == GEAR_P || tgt == GEAR_R) && !spd0) return 1'b0;
        if (cur == GEAR_P && !(brake && acc)) return 1'b0;
        if (((cur == GEAR_R && tgt == GEAR_D) || (cur == GEAR_D && tgt == GEAR_R)) && !spd0)
            return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < KEY_NUM; k++) begin
            m_hist[k] = '0;
            m_lvl[k]  = 1'b0;
            m_rise[k] = 1'b0;
        end
        m_pwr = PWR_OFF;
        m_gear = GEAR_P;
        m_crank_ticks = 0;
        m_rej = 1'b0;
        m_fail = 1'b0;
    endtask

    task automatic model_step();
        bit         spd0 = (speed == 8'd0);
        bit         acc_pre = (m_pwr != PWR_OFF);
        logic [1:0] p = m_pwr;
        logic [3:0] g_pre = m_gear;
        logic [3:0] tgt = GEAR_P;
        bit         have = 1'b1;
        bit         raw [KEY_NUM];
        bit         flip;
        raw = '{key_start, key_brake, key_p, key_r, key_n, key_d};
        m_rej = 1'b0;
        m_fail = 1'b0;
        if (m_rise[KEY_P]) tgt = GEAR_P;
        else if (m_rise[KEY_R]) tgt = GEAR_R;
        else if (m_rise[KEY_N]) tgt = GEAR_N;
        else if (m_rise[KEY_D]) tgt = GEAR_D;
        else have = 1'b0;
        if (have && tgt != m_gear) begin
            if (gear_ok(m_gear, tgt, spd0, m_lvl[KEY_BRAKE], acc_pre)) m_gear = tgt;
            else m_rej = 1'b1;
        end
        if (p == PWR_OFF || p == PWR_ACC) begin
            if (m_rise[KEY_START]) begin
                if (m_lvl[KEY_BRAKE] && (g_pre == GEAR_P || g_pre == GEAR_N)) begin
                    m_pwr = PWR_CRANK;
                    m_crank_ticks = 0;
                end else begin
                    m_pwr = (p == PWR_OFF) ? PWR_ACC : PWR_OFF;
                end
            end
        end else if (p == PWR_CRANK) begin
            if (!m_lvl[KEY_START]) begin
                m_pwr = PWR_ACC;
                m_fail = 1'b1;
            end else if (tick_1s) begin
                m_crank_ticks++;
                if (m_crank_ticks >= CS) m_pwr = PWR_RUN;
            end
        end else if (m_rise[KEY_START] && spd0) begin
            m_pwr = PWR_OFF;
        end
        if (AUTO_PARK && m_pwr == PWR_OFF && (p == PWR_RUN || p == PWR_ACC) && spd0) begin
            m_gear = GEAR_P;
            m_rej = 1'b0;
        end
        // Level follows raw once the last DN samples all disagree with it.
        for (int k = 0; k < KEY_NUM; k++) begin
            m_rise[k] = 1'b0;
            if (tick_spd) begin
                m_hist[k] = {m_hist[k][14:0], raw[k]};
                flip = 1'b1;
                for (int i = 0; i < DN; i++)
                    if (m_hist[k][i] == m_lvl[k]) flip = 1'b0;
                if (flip) begin
                    m_lvl[k]  = raw[k];
                    m_rise[k] = raw[k];
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        if (global_safe_rst) model_reset();
        else model_step();
        #1;
        check("outputs",
              {6'd0, power_state, engine_on, acc_on, gear, shift_reject, start_fail},
              {6'd0, m_pwr, (m_pwr == PWR_RUN), (m_pwr != PWR_OFF), m_gear, m_rej, m_fail});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_spd = 1'b1; cyc();
            tick_spd = 1'b0; cyc();
        end
    endtask

    task automatic sec_pulse();
        tick_1s = 1'b1; cyc();
        tick_1s = 1'b0; cyc();
    endtask

    // ---------------- table ----------------
    typedef struct {
        bit st, br, p, r, n, d;
        int spd;
        int nt;
        int n1s;
        logic [1:0] ep;
        logic [3:0] eg;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [3:0] g_off_d, g_off_n;
        g_off_d = AUTO_PARK ? GEAR_P : GEAR_D;
        g_off_n = AUTO_PARK ? GEAR_P : GEAR_N;
        //              st br p  r  n  d  spd nt n1s  pwr        gear
        tbl.push_back('{0, 0, 0, 0, 0, 1, 0,  2, 0, PWR_OFF,   GEAR_P});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0,  3, 0, PWR_OFF,   GEAR_P});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0,  3, 0, PWR_ACC,   GEAR_P});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0,  3, 0, PWR_ACC,   GEAR_P});
        tbl.push_back('{0, 1, 0, 0, 0, 1, 0,  3, 0, PWR_ACC,   GEAR_D});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0,  3, 0, PWR_ACC,   GEAR_D});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0,  3, 0, PWR_OFF,   g_off_d});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0,  3, 0, PWR_OFF,   g_off_d});
        tbl.push_back('{0, 1, 0, 0, 1, 0, 0,  3, 0, PWR_OFF,   GEAR_N});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0,  3, 0, PWR_OFF,   GEAR_N});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0,  3, 0, PWR_CRANK, GEAR_N});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0,  0, 2, PWR_RUN,   GEAR_N});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 40, 3, 0, PWR_RUN,   GEAR_N});
        tbl.push_back('{0, 1, 0, 0, 0, 1, 40, 3, 0, PWR_RUN,   GEAR_D});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 40, 3, 0, PWR_RUN,   GEAR_D});
        tbl.push_back('{0, 1, 0, 1, 0, 0, 40, 3, 0, PWR_RUN,   GEAR_D});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 40, 3, 0, PWR_RUN,   GEAR_D});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 40, 3, 0, PWR_RUN,   GEAR_D});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0,  3, 0, PWR_RUN,   GEAR_D});
        tbl.push_back('{0, 1, 1, 0, 1, 0, 0,  3, 0, PWR_RUN,   GEAR_P});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0,  3, 0, PWR_RUN,   GEAR_P});
        tbl.push_back('{0, 1, 0, 0, 1, 0, 0,  3, 0, PWR_RUN,   GEAR_N});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0,  3, 0, PWR_RUN,   GEAR_N});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0,  3, 0, PWR_OFF,   g_off_n});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0,  3, 0, PWR_OFF,   g_off_n});

        // Reset state
        model_reset();
        repeat (3) cyc();
        #1;
        check("reset_state", {6'd0, power_state, engine_on, acc_on, gear, shift_reject, start_fail},
              {6'd0, PWR_OFF, 1'b0, 1'b0, GEAR_P, 1'b0, 1'b0});
        global_safe_rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            {key_start, key_brake, key_p, key_r, key_n, key_d} =
                {tbl[i].st, tbl[i].br, tbl[i].p, tbl[i].r, tbl[i].n, tbl[i].d};
            speed = 8'(tbl[i].spd);
            ticks(tbl[i].nt);
            cyc(); cyc();
            for (int s = 0; s < tbl[i].n1s; s++) sec_pulse();
            cyc(); cyc();
            check($sformatf("row%0d_pwr", i), {14'd0, power_state}, {14'd0, tbl[i].ep});
            check($sformatf("row%0d_gear", i), {12'd0, gear}, {12'd0, tbl[i].eg});
            $display("row %0d: pwr=%0d gear=%0d", i, power_state, gear);
        end

        // Crank timing: tick_1s in the entry cycle is not counted.
        key_start = 1'b1;
        ticks(2);
        tick_spd = 1'b1; cyc();
        tick_spd = 1'b0; tick_1s = 1'b1; cyc();
        tick_1s = 1'b0;
        check("crank_entry", {14'd0, power_state}, {14'd0, PWR_CRANK});
        cyc();
        sec_pulse();
        check("crank_after_1s", {14'd0, power_state, engine_on}, {14'd0, PWR_CRANK, 1'b0});
        tick_1s = 1'b1; cyc();
        tick_1s = 1'b0;
        check("run_after_2s", {14'd0, power_state, engine_on}, {14'd0, PWR_RUN, 1'b1});
        $display("seq crank: pwr=%0d engine_on=%0b", power_state, engine_on);
        key_start = 1'b0; ticks(3);
        key_start = 1'b1; ticks(3); cyc();
        check("run_to_off", {14'd0, power_state}, {14'd0, PWR_OFF});

        // Crank abort, with a coincident tick_1s on the release cycle.
        key_start = 1'b0; ticks(3);
        key_start = 1'b1; ticks(3);
        check("abort_crank_entry", {14'd0, power_state}, {14'd0, PWR_CRANK});
        sec_pulse();
        key_start = 1'b0;
        ticks(2);
        tick_spd = 1'b1; cyc();
        tick_spd = 1'b0; tick_1s = 1'b1; cyc();
        tick_1s = 1'b0;
        check("abort_state", {14'd0, power_state, start_fail}, {13'd0, PWR_ACC, 1'b1});
        cyc();
        check("abort_pulse_end", {15'd0, start_fail}, 16'd0);
        $display("seq abort: pwr=%0d", power_state);

        // Reset asserted mid-crank takes effect at once, with no start_fail.
        key_start = 1'b1; ticks(3);
        check("rst_crank_entry", {14'd0, power_state}, {14'd0, PWR_CRANK});
        sec_pulse();
        #2 global_safe_rst = 1'b1;
        model_reset();
        #1;
        check("rst_async", {6'd0, power_state, engine_on, acc_on, gear, shift_reject, start_fail},
              {6'd0, PWR_OFF, 1'b0, 1'b0, GEAR_P, 1'b0, 1'b0});
        {key_start, key_brake, key_p, key_r, key_n, key_d} = 6'b0;
        repeat (3) cyc();
        global_safe_rst = 1'b0;
        repeat (3) cyc();
        $display("seq reset: pwr=%0d gear=%0d", power_state, gear);

        // Randomized phase against the model.
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 5))
                    0: key_start = ~key_start;
                    1: key_brake = ~key_brake;
                    2: key_p = ~key_p;
                    3: key_r = ~key_r;
                    4: key_n = ~key_n;
                    default: key_d = ~key_d;
                endcase
            end
            if ($urandom_range(0, 39) == 0)
                speed = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            tick_spd = ($urandom_range(0, 2) == 0);
            tick_1s  = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 1999) == 0) global_safe_rst = 1'b1;
            else global_safe_rst = 1'b0;
            cyc();
        end
        $display("random phase done: pwr=%0d gear=%0d", power_state, gear);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
